paralleltoserial: RTL and testbench

- Transmit-side counterpart of the serialtopar receiver.
- Accepts 8-bit bytes through a valid/ready handshake and serializes them MSB-first on a 1-bit line, one bit per clk_32f cycle.
- After reset it sends a comma (COM) training sequence so the downstream serialtopar can lock.
- Once trained, it sends data bytes, or IDL fill bytes when no data is offered.

---
 rtl/paralleltoserial.sv | 79 +++++++
 tb/tb_paralleltoserial.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/paralleltoserial.sv
// Byte-to-serial transmitter: MSB-first, one bit per clk_32f edge, with a comma training
// preamble after reset and idle fill when no byte is offered.
module paralleltoserial #(
   parameter logic [7:0]  COM        = 8'hBC,
   parameter logic [7:0]  IDL        = 8'h7C,
   parameter int unsigned SYNC_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset_L,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       data_out,
   output logic       ready_out,
   output logic       active_out
);

   typedef enum logic {StSync, StActive} state_e;

   localparam logic [3:0] SyncLast = 4'(SYNC_COUNT - 1);

   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] sync_cnt_q, sync_cnt_d;
   logic [6:0] shreg_q, shreg_d;
   logic       data_out_q, data_out_d;
   logic       load_slot;
   logic [7:0] word;

   assign load_slot = (bit_cnt_q == 3'd0);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      sync_cnt_d = sync_cnt_q;
      shreg_d    = {shreg_q[5:0], 1'b0};
      data_out_d = shreg_q[6];
      word       = IDL;

      if (load_slot) begin
         unique case (state_q)
            StSync: begin
               word       = COM;
               sync_cnt_d = sync_cnt_q + 4'd1;
               if (sync_cnt_q == SyncLast) begin
                  state_d = StActive;
               end
            end
            StActive: begin
               // valid_in is sampled only here, so a byte offered mid-word simply waits
               word = valid_in ? data_in : IDL;
            end
            default: word = IDL;
         endcase
         data_out_d = word[7];
         shreg_d    = word[6:0];
      end
   end

   always_ff @(posedge clk_32f) begin
      if (!reset_L) begin
         state_q    <= StSync;
         bit_cnt_q  <= 3'd0;
         sync_cnt_q <= 4'd0;
         shreg_q    <= 7'd0;
         data_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sync_cnt_q <= sync_cnt_d;
         shreg_q    <= shreg_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out   = data_out_q;
   assign ready_out  = reset_L & (state_q == StActive) & load_slot;
   assign active_out = reset_L & (state_q == StActive);

endmodule

// File: tb/tb_paralleltoserial.sv
// Directed bench for paralleltoserial: an edge-count model predicts every serial bit, and a
// bench-side deserializer checks the byte stream against the accepted-byte queue.
module tb_paralleltoserial;

   localparam int SYNC = 4;
   localparam logic [7:0] COM = 8'hBC;
   localparam logic [7:0] IDL = 8'h7C;

   logic       clk_32f;
   logic       reset_L;
   logic [7:0] data_in;
   logic       valid_in;
   logic       data_out;
   logic       ready_out;
   logic       active_out;

   int total = 0;
   int bad   = 0;

   paralleltoserial #(
      .COM       (COM),
      .IDL       (IDL),
      .SYNC_COUNT(SYNC)
   ) dut (
      .clk_32f   (clk_32f),
      .reset_L   (reset_L),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .data_out  (data_out),
      .ready_out (ready_out),
      .active_out(active_out)
   );

   initial clk_32f = 1'b0;
   always #5 clk_32f = ~clk_32f;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs as seen by the DUT at the most recent rising edge
   logic       s_seen = 1'b0;
   logic       s_rst;
   logic       s_valid;
   logic [7:0] s_data;

   always @(posedge clk_32f) begin
      s_seen  <= 1'b1;
      s_rst   <= reset_L;
      s_valid <= valid_in;
      s_data  <= data_in;
   end

   // Model: e counts edges since reset release; byte n occupies edges 8n+1..8n+8
   int          e      = 0;
   logic        mdl_ok = 1'b0;
   logic        exp_do;
   logic        exp_act;
   logic [7:0]  word;
   logic [31:0] rx_sh;
   logic [7:0]  exp_q[$];
   logic [7:0]  got;

   always @(negedge clk_32f) begin
      if (s_seen) begin
         if (!s_rst) begin
            e       = 0;
            exp_do  = 1'b0;
            exp_act = 1'b0;
            mdl_ok  = 1'b1;
            rx_sh   = 32'd0;
            exp_q.delete();
         end else if (mdl_ok) begin
            if (e % 8 == 0) begin
               if (e < 8 * SYNC) word = COM;
               else if (s_valid) begin
                  word = s_data;
                  exp_q.push_back(s_data);
               end else word = IDL;
            end
            exp_do  = word[7 - (e % 8)];
            e       = e + 1;
            exp_act = (e >= 8 * (SYNC - 1) + 1);
            rx_sh   = {rx_sh[30:0], data_out};
            if (e % 8 == 0 && e / 8 > SYNC && rx_sh[7:0] != IDL) begin
               got = rx_sh[7:0];
               if (exp_q.size() == 0) check("loopback_unexpected", {24'd0, got}, 32'hFFFF_FFFF);
               else check("loopback_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
            end
         end
         if (mdl_ok) begin
            check("data_out", {31'd0, data_out}, {31'd0, exp_do});
            check("active_out", {31'd0, active_out}, {31'd0, reset_L & exp_act});
            check("ready_out", {31'd0, ready_out},
                  {31'd0, reset_L && (e % 8 == 0) && (e >= 8 * SYNC)});
         end
      end
   end

   task automatic wait_e(input int target);
      for (int n = 0; n < 300; n++) begin
         if (e == target) return;
         @(negedge clk_32f);
         #1;
      end
      check("wait_timeout", e, target);
   endtask

   task automatic send(input logic [7:0] b);
      data_in  = b;
      valid_in = 1'b1;
      for (int n = 0; n < 20; n++) begin
         if (ready_out) begin
            @(negedge clk_32f);
            #1;
            valid_in = 1'b0;
            data_in  = 8'hxx;
            return;
         end
         @(negedge clk_32f);
         #1;
      end
      valid_in = 1'b0;
      check("send_timeout", 32'd0, {24'd0, b});
   endtask

   int rdy_cnt;

   initial begin
      reset_L  = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'h00;
      repeat (2) @(posedge clk_32f);
      @(negedge clk_32f);
      #1;
      check("reset_data_out", {31'd0, data_out}, 32'd0);
      check("reset_ready", {31'd0, ready_out}, 32'd0);
      check("reset_active", {31'd0, active_out}, 32'd0);
      reset_L = 1'b1;

      // Training preamble and activation timing
      wait_e(24);
      check("active_before_25", {31'd0, active_out}, 32'd0);
      wait_e(25);
      check("active_at_25", {31'd0, active_out}, 32'd1);
      wait_e(31);
      check("ready_before_33", {31'd0, ready_out}, 32'd0);
      wait_e(32);
      check("ready_for_33", {31'd0, ready_out}, 32'd1);
      check("train_bits", rx_sh, 32'hBCBC_BCBC);

      // Idle fill
      wait_e(40);
      check("idle_byte", {24'd0, rx_sh[7:0]}, 32'h7C);
      rdy_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (ready_out) rdy_cnt++;
         @(negedge clk_32f);
         #1;
      end
      check("idle_ready_pulses", rdy_cnt, 2);

      // Single byte offered mid-word
      wait_e(60);
      send(8'hA5);
      wait_e(72);
      check("single_A5", {24'd0, rx_sh[7:0]}, 32'hA5);
      wait_e(80);
      check("after_A5_idle", {24'd0, rx_sh[7:0]}, 32'h7C);

      // Back-to-back bytes
      send(8'h01);
      send(8'hFF);
      wait_e(96);
      check("b2b_01_FF", {16'd0, rx_sh[15:0]}, 32'h01FF);

      // Reset while bit 4 of a byte is due
      send(8'h3C);
      wait_e(100);
      reset_L = 1'b0;
      @(negedge clk_32f);
      #1;
      check("midreset_data_out", {31'd0, data_out}, 32'd0);
      check("midreset_active", {31'd0, active_out}, 32'd0);
      reset_L = 1'b1;
      wait_e(32);
      check("retrain_bits", rx_sh, 32'hBCBC_BCBC);
      send(8'h5A);
      wait_e(40);
      check("post_reset_5A", {24'd0, rx_sh[7:0]}, 32'h5A);
      wait_e(48);
      check("loopback_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
